// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//
// Purpose:
//   Turns single-cycle pulse requests into output pulses of fixed length.
//   Each accepted request plays LEN cycles of lo=1. A gap of GAP low cycles
//   always follows. Requests that arrive while a pulse or gap is still
//   playing are counted in a saturating pending counter. They are played
//   back one after another. A request that arrives while the counter is
//   full is dropped, and the sticky ovf flag records the drop.
//
// Parameters:
//   LEN     cycles lo is held high per pulse (1..255)
//   GAP     low cycles forced between output pulses (1..255)
//   PEND_W  width of the pending counter (max pending = 2^PEND_W-1)
//
// Ports:
//   clk       input   single clock, rising-edge active
//   rst       input   asynchronous, active-low reset
//   pi        input   single-cycle pulse request; one pulse per cycle high
//   clr_ovf   input   synchronous clear of the ovf flag
//   lo        output  stretched output level (registered)
//   busy      output  high whenever the FSM is not idle (registered)
//   pend_cnt  output  accepted pulses not yet played (registered)
//   ovf       output  sticky flag, set when a pulse is dropped at saturation

module pulse_stretcher #(
  parameter int LEN    = 4,
  parameter int GAP    = 2,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pi,
  input  logic              clr_ovf,
  output logic              lo,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // The cycle counter counts down to zero.
  // A counter value of zero marks the final cycle of the current state.
  localparam logic [7:0]        LEN_RELOAD = 8'(LEN - 1);
  localparam logic [7:0]        GAP_RELOAD = 8'(GAP - 1);
  localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                drop;

  // Next-state logic. All outputs are derived from the next state.
  // This lets the output flops change on the same edge as the state flop.
  // As a result, lo and busy are registered, and pi has no
  // combinational path to any output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The pending counter is always zero in idle.
        // A request therefore starts a pulse directly.
        if (pi) begin
          state_d = ST_HIGH;
          cnt_d   = LEN_RELOAD;
        end
      end

      ST_HIGH: begin
        if (pi) begin
          if (pend_q == PEND_MAX) drop = 1'b1;
          else                    pend_d = pend_q + PEND_ONE;
        end
        if (cnt_q == 8'd0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_GAP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
          if (pi) begin
            if (pend_q == PEND_MAX) drop = 1'b1;
            else                    pend_d = pend_q + PEND_ONE;
          end
        end else if (pend_q != '0 || pi) begin
          // Final gap cycle: the next pulse starts immediately.
          // If a pending pulse is consumed and a new request is also
          // queued in this cycle, the count stays the same, so no
          // drop can occur here.
          // With nothing pending, a new request is played directly and
          // never enters the counter.
          state_d = ST_HIGH;
          cnt_d   = LEN_RELOAD;
          if (pend_q != '0 && !pi) pend_d = pend_q - PEND_ONE;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        pend_d  = '0;
      end
    endcase

    // A drop in the same cycle as a clear wins, so ovf stays set.
    ovf_d  = drop | (ovf_q & ~clr_ovf);
    lo_d   = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  // Single state register for the FSM, its counters and registered outputs.
  // Reset takes effect immediately, without waiting for a clock edge.
  // While rst is low, requests on pi have no effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      lo_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign lo       = lo_q;
  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher
//
// Self-checking bench for pulse_stretcher with LEN=4, GAP=2, PEND_W=3.
//
// The reference model tracks a position within the pulse-plus-gap period,
// where 0 means idle. Each driven cycle pushes the model's expected
// post-edge outputs onto a queue. Shortly after the edge, the entry is
// popped and compared with the DUT outputs.

module tb_pulse_stretcher;

  localparam int LEN    = 4;
  localparam int GAP    = 2;
  localparam int PEND_W = 3;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic              clk;
  logic              rst;
  logic              pi;
  logic              clr_ovf;
  logic              lo;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              ovf;

  typedef struct {
    logic       lo;
    logic       busy;
    logic [7:0] pend;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  int checks;
  int errors;
  int cyc;

  int m_pos;
  int m_pend;
  bit m_ovf;

  pulse_stretcher #(
    .LEN   (LEN),
    .GAP   (GAP),
    .PEND_W(PEND_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pi      (pi),
    .clr_ovf (clr_ovf),
    .lo      (lo),
    .busy    (busy),
    .pend_cnt(pend_cnt),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stops the run if something stalls far beyond the expected length.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advances the reference model by one rising edge.
  task automatic modelStep(input logic r, input logic p, input logic c);
    bit dropped;
    dropped = 1'b0;
    if (!r) begin
      m_pos  = 0;
      m_pend = 0;
      m_ovf  = 1'b0;
    end else begin
      if (m_pos == 0) begin
        if (p) m_pos = 1;
      end else if (m_pos == LEN + GAP) begin
        if (m_pend > 0 || p) begin
          m_pos = 1;
          if (m_pend > 0 && !p) m_pend = m_pend - 1;
        end else begin
          m_pos = 0;
        end
      end else begin
        m_pos = m_pos + 1;
        if (p) begin
          if (m_pend < PMAX) m_pend = m_pend + 1;
          else               dropped = 1'b1;
        end
      end
      if (dropped)  m_ovf = 1'b1;
      else if (c)   m_ovf = 1'b0;
    end
  endtask

  // Drives one cycle of inputs and records the expected outcome.
  // It then checks the DUT just after the rising edge.
  task automatic applyStimulus(input logic r, input logic p, input logic c);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst     = r;
    pi      = p;
    clr_ovf = c;
    modelStep(r, p, c);
    e.lo   = (m_pos >= 1 && m_pos <= LEN);
    e.busy = (m_pos != 0);
    e.pend = 8'(m_pend);
    e.ovf  = m_ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = exp_q.pop_front();
    checkOutput($sformatf("lo@%0d", cyc), 32'(lo), 32'(got.lo));
    checkOutput($sformatf("busy@%0d", cyc), 32'(busy), 32'(got.busy));
    checkOutput($sformatf("pend@%0d", cyc), 32'(pend_cnt), 32'(got.pend));
    checkOutput($sformatf("ovf@%0d", cyc), 32'(ovf), 32'(got.ovf));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    m_pos   = 0;
    m_pend  = 0;
    m_ovf   = 1'b0;
    rst     = 1'b0;
    pi      = 1'b0;
    clr_ovf = 1'b0;

    // Reset state, before any clock edge.
    #2;
    checkOutput("reset_lo", 32'(lo), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_pend", 32'(pend_cnt), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);

    // Requests while reset is held must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(2);

    // Single pulse.
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(8);
    checkOutput("single_idle_busy", 32'(busy), 32'd0);

    // Queued pulse: requests in cycles 0 and 2.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(14);

    // Direct hand-off: a request in the final gap cycle.
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(5);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(12);

    // Saturation: the counter reaches 7, and later pulses are dropped.
    // The last request coincides with clr_ovf, so ovf must stay set.
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("sat_pend", 32'(pend_cnt), 32'd7);
    checkOutput("sat_ovf_held", 32'(ovf), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("ovf_cleared", 32'(ovf), 32'd0);
    idleCycles(55);
    checkOutput("drain_pend", 32'(pend_cnt), 32'd0);
    checkOutput("drain_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a pulse while pulses are pending.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("pre_rst_pend", 32'(pend_cnt), 32'd2);
    #2;
    rst = 1'b0;
    pi  = 1'b0;
    #1;
    checkOutput("async_lo", 32'(lo), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_pend", 32'(pend_cnt), 32'd0);
    checkOutput("async_ovf", 32'(ovf), 32'd0);
    modelStep(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(8);

    // Random traffic, including occasional overflow clears.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
    end
    idleCycles(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
